seq_mult_unit: RTL
==================

Name: seq_mult_unit

Overview:
- Self-contained W-bit sequential shift-add multiplier: control FSM plus multiplicand, multiplier and accumulator datapath in one block.
- Successor to the fixed-width add/shift controller, adding:
  - parametrised width;
  - a signed/unsigned mode;
  - optional early termination;
  - valid/ready handshakes on both sides, and an abort.
- Sits between operand-issue logic and a result consumer; one operation in flight at a time.

Parameters:
W  8  operand width in bits (>= 2); product width is 2W
EARLY_TERM  1  1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run W iterations

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  W  multiplicand
b  input  W  multiplier
signed_mode  input  1  1 = a, b, p are two's complement; 0 = unsigned; sampled with operands
abort  input  1  synchronous cancel of the current operation
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
p  output  2W  product
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst high at an edge):
  - state goes to IDLE; all datapath registers are cleared.
  - While rst is high: in_ready=0, out_valid=0, busy=0, p=0.
  - Reset mid-operation discards the operation; no out_valid is produced.
- States and transitions:
  - IDLE → ADD, on accept.
  - ADD → SHIFT.
  - SHIFT → ADD, or → FIX when iterations are done.
  - FIX → DONE.
  - DONE → IDLE, on out_valid & out_ready.
- Handshakes:
  - in_ready = 1 only in IDLE with rst low.
  - Accept occurs on an edge where in_valid & in_ready. At that edge a, b and signed_mode are captured.
  - Inputs are ignored in every other state.
- Signed handling (on accept):
  - signed_mode=1: the magnitudes |a| and |b| are stored as W-bit unsigned values, and neg = a[W-1] ^ b[W-1] is latched. The magnitude of the most negative value, 2^(W-1), fits in W bits.
  - signed_mode=0: a and b are stored as-is and neg=0.
- Per-iteration work:
  - The accumulator is 2W bits, cleared on accept; an iteration counter loads W.
  - ADD: if the multiplier LSB is 1, add the multiplicand, shifted left by the number of completed iterations, into the accumulator. No overflow is possible.
  - SHIFT: shift the multiplier right by 1 and decrement the counter.
- Leaving SHIFT:
  - Go to FIX if the counter reaches 0, or if EARLY_TERM=1 and the post-shift multiplier is all zero.
  - Otherwise return to ADD.
- FIX: if neg, p_reg = -acc (2W-bit two's complement); else p_reg = acc.
- DONE:
  - out_valid = 1 and p = p_reg, both held stable until out_ready.
  - out_valid falls on the edge after the handshake.
  - p holds its last value after returning to IDLE.
- Latency, counted from the accept edge to the edge at which out_valid rises:
  - EARLY_TERM=0: 2W+1.
  - EARLY_TERM=1: 2k+1, where k = index of the highest set bit of the stored multiplier (magnitude) plus 1, with minimum k=1 (multiplier = 0 gives latency 3).
- Back-to-back: the earliest next accept is the edge after the DONE handshake edge, i.e. one IDLE cycle between operations.
- Abort:
  - abort=1 at an edge in any non-IDLE state sends the FSM to IDLE and drops out_valid; no product is delivered.
  - abort in IDLE has no effect.
  - abort has priority over the DONE handshake and over accept.
  - rst has priority over abort.
- Zero operands: correct zero product; in signed mode neg is forced to 0 when either operand is zero, so no -0 arises.

Test Plan:
- W=8, EARLY_TERM=0, unsigned: a=255, b=255 → p=65025 (0xFE01), out_valid exactly 17 cycles after accept, busy high throughout.
- W=8, signed: a=-128, b=-128 → p=16384 (0x4000); a=-3, b=5 → p=0xFFF1 (-15); a=127, b=-1 → p=0xFF81.
- W=8, EARLY_TERM=1, unsigned:
  - a=200, b=3 → p=600, latency 5.
  - b=0 → p=0, latency 3.
  - b=0x80 → latency 17.
- Backpressure: out_ready held low 10 cycles after out_valid → p and out_valid stable; in_ready stays 0; release → out_valid falls next edge; in_ready=1 one cycle later.
- Abort: accept a=7, b=9, assert abort 4 cycles later → IDLE next edge, no out_valid ever; a following op a=6, b=7 yields p=42.
- Reset: rst asserted mid-operation → next edge in_ready=0, out_valid=0, p=0, busy=0; after rst falls, in_ready=1 and a new operation completes correctly.

Source files
------------

// File: rtl/seq_mult_unit.sv
// W-bit sequential shift-add multiplier with signed/unsigned mode, optional early
// termination, valid/ready handshakes on both sides and a synchronous abort.
module seq_mult_unit #(
  parameter int W          = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           signed_mode,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADD   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q,  state_d;
  logic [PW-1:0] mcand_q,  mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [PW-1:0] acc_q,    acc_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          neg_q,    neg_d;
  logic [PW-1:0] p_q,      p_d;

  logic [W-1:0]  a_mag, b_mag;
  logic          accept;
  logic          last_iter;

  // Magnitudes fit in W bits: |-2^(W-1)| = 2^(W-1) is still representable unsigned.
  assign a_mag  = (signed_mode && a[W-1]) ? (~a + W'(1)) : a;
  assign b_mag  = (signed_mode && b[W-1]) ? (~b + W'(1)) : b;
  assign accept = in_valid && in_ready;

  assign last_iter = (cnt_q == CW'(1)) ||
                     ((EARLY_TERM != 0) && (mplier_q[W-1:1] == '0));

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d  = S_ADD;
            mcand_d  = {{W{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = CW'(W);
            neg_d    = signed_mode && (a[W-1] ^ b[W-1]) && (|a) && (|b);
          end
        end
        S_ADD: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          mplier_d = mplier_q >> 1;
          mcand_d  = mcand_q << 1;
          cnt_d    = cnt_q - CW'(1);
          state_d  = last_iter ? S_FIX : S_ADD;
        end
        S_FIX: begin
          p_d     = neg_q ? (~acc_q + PW'(1)) : acc_q;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  // Outputs are gated by rst so they read idle/zero for the whole time reset is held.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE) && !rst;
  assign busy      = (state_q != S_IDLE) && !rst;
  assign p         = rst ? '0 : p_q;

endmodule
